ahb_lite_interconnect_n: RTL and testbench

Parametrised AHB-Lite slave-side interconnect for one master and NUM_SLAVES slaves. It combines the address decoder, a built-in default (error) slave and the response multiplexer. The data-phase select is registered on HCLK, qualified by HREADY. Unmapped accesses get a protocol-correct two-cycle ERROR and are logged in a saturating error counter with last-error address capture. It sits between the bus master and slaves such as the Triple-DES AHB slave controller.

---
 rtl/ahb_lite_interconnect_n.sv | 137 +++++++++++++
 tb/tb_ahb_lite_interconnect_n.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_interconnect_n.sv
// AHB-Lite slave-side interconnect: address decode, default error slave,
// registered data-phase select and response mux, with unmapped-access logging.
module ahb_lite_interconnect_n #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hF000_0000, 32'hF000_0000},
  parameter int ERR_CNT_W  = 16
) (
  input  logic                         i_hclk,
  input  logic                         i_hreset_n,
  input  logic                         i_hsel,
  input  logic [ADDR_W-1:0]            i_haddr,
  input  logic [1:0]                   i_htrans,
  output logic [NUM_SLAVES-1:0]        o_hselx,
  input  logic [NUM_SLAVES-1:0]        i_hreadyoutx,
  input  logic [NUM_SLAVES-1:0]        i_hrespx,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_hrdatax,
  output logic                         o_hready,
  output logic                         o_hresp,
  output logic [DATA_W-1:0]            o_hrdata,
  input  logic                         i_clear_err,
  output logic [ERR_CNT_W-1:0]         o_err_count,
  output logic [ADDR_W-1:0]            o_err_addr
);

  localparam int SEL_W = (NUM_SLAVES < 2) ? 1 : $clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0] SEL_DEFAULT = SEL_W'(NUM_SLAVES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } def_state_t;

  def_state_t          r_state;
  def_state_t          w_state_next;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_idx;
  logic                w_hit;
  logic                w_trigger;
  logic                w_def_ready;
  logic                w_def_resp;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [ADDR_W-1:0]   r_err_addr;

  // Scan from the top down so the lowest matching index wins on overlap.
  always_comb begin
    w_hit = 1'b0;
    w_idx = SEL_DEFAULT;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (i_hsel && ((i_haddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    o_hselx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_hselx[i] = w_hit && (w_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_sel <= SEL_DEFAULT;
    end else if (o_hready) begin
      r_sel <= w_idx;
    end
  end

  assign w_trigger = o_hready && !w_hit && i_hsel && i_htrans[1];

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ERR1 can never retrigger because HREADY is low there, so it always moves on.
  always_comb begin
    w_state_next = S_IDLE;
    w_def_ready  = 1'b1;
    w_def_resp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) w_state_next = S_ERR1;
      end
      S_ERR1: begin
        w_def_ready  = 1'b0;
        w_def_resp   = 1'b1;
        w_state_next = S_ERR2;
      end
      S_ERR2: begin
        w_def_resp = 1'b1;
        if (w_trigger) w_state_next = S_ERR1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_hready = w_def_ready;
    o_hresp  = w_def_resp;
    o_hrdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == SEL_W'(i)) begin
        o_hready = i_hreadyoutx[i];
        o_hresp  = i_hrespx[i];
        o_hrdata = i_hrdatax[i*DATA_W +: DATA_W];
      end
    end
  end

  // Clear wins over a same-cycle trigger; the count sticks at all-ones.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else if (i_clear_err) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else if (w_trigger) begin
      if (r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_W'(1);
      r_err_addr <= i_haddr;
    end
  end

  assign o_err_count = r_err_count;
  assign o_err_addr  = r_err_addr;

endmodule

// File: tb/tb_ahb_lite_interconnect_n.sv
// Randomised and directed bench for ahb_lite_interconnect_n, checked against
// a transfer-level reference model (data-phase owner, error cycles remaining).
module tb_ahb_lite_interconnect_n;

  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int CW = 2;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic clk = 1'b0;
  logic hresetN;
  logic hsel;
  logic [AW-1:0] haddr;
  logic [1:0] htrans;
  logic [NS-1:0] hselx;
  logic [NS-1:0] hreadyoutx;
  logic [NS-1:0] hrespx;
  logic [NS*DW-1:0] hrdatax;
  logic hready;
  logic hresp;
  logic [DW-1:0] hrdata;
  logic clearErr;
  logic [CW-1:0] errCount;
  logic [AW-1:0] errAddr;

  int checks = 0;
  int failures = 0;

  int mSel;
  int mLeft;
  int mCount;
  logic [AW-1:0] mAddr;

  always #5 clk = ~clk;

  ahb_lite_interconnect_n #(
    .NUM_SLAVES(NS),
    .ADDR_W(AW),
    .DATA_W(DW),
    .SLAVE_BASE({32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000}),
    .ERR_CNT_W(CW)
  ) dut (
    .i_hclk(clk),
    .i_hreset_n(hresetN),
    .i_hsel(hsel),
    .i_haddr(haddr),
    .i_htrans(htrans),
    .o_hselx(hselx),
    .i_hreadyoutx(hreadyoutx),
    .i_hrespx(hrespx),
    .i_hrdatax(hrdatax),
    .o_hready(hready),
    .o_hresp(hresp),
    .o_hrdata(hrdata),
    .i_clear_err(clearErr),
    .o_err_count(errCount),
    .o_err_addr(errAddr)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Slave map: top nibble 0 -> slave 0, top nibble 1 -> slave 1, else unmapped.
  function automatic int decodeIdx(input logic sel, input logic [AW-1:0] a);
    if (!sel) return -1;
    if (a[31:28] == 4'h0) return 0;
    if (a[31:28] == 4'h1) return 1;
    return -1;
  endfunction

  task automatic applyStimulus(input logic sel, input logic [AW-1:0] addr, input logic [1:0] trans,
                               input logic [NS-1:0] rdy, input logic [NS-1:0] resp, input logic clr);
    hsel = sel;
    haddr = addr;
    htrans = trans;
    hreadyoutx = rdy;
    hrespx = resp;
    clearErr = clr;
  endtask

  task automatic modelReset();
    mSel = -1;
    mLeft = 0;
    mCount = 0;
    mAddr = '0;
  endtask

  // Called just after a negedge with inputs applied; checks, then crosses one posedge.
  task automatic stepCycle();
    int d;
    logic [NS-1:0] eHsel;
    logic eReady;
    logic eResp;
    logic [DW-1:0] eData;
    logic trig;
    #1;
    d = decodeIdx(hsel, haddr);
    eHsel = (d < 0) ? '0 : NS'(1 << d);
    if (mSel >= 0) begin
      eReady = hreadyoutx[mSel];
      eResp = hrespx[mSel];
      eData = hrdatax[mSel*DW +: DW];
    end else begin
      eReady = (mLeft != 2);
      eResp = (mLeft != 0);
      eData = '0;
    end
    checkOutput("hselx", DW'(hselx), DW'(eHsel));
    checkOutput("hready", DW'(hready), DW'(eReady));
    checkOutput("hresp", DW'(hresp), DW'(eResp));
    checkOutput("hrdata", hrdata, eData);
    checkOutput("err_count", DW'(errCount), DW'(mCount));
    checkOutput("err_addr", DW'(errAddr), DW'(mAddr));
    trig = eReady && hsel && htrans[1] && (d < 0);
    @(posedge clk);
    if (clearErr) begin
      mCount = 0;
      mAddr = '0;
    end else if (trig) begin
      mCount = (mCount == (1 << CW) - 1) ? mCount : mCount + 1;
      mAddr = haddr;
    end
    if (trig) mLeft = 2;
    else if (mLeft > 0) mLeft--;
    if (eReady) mSel = d;
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [3:0] nib;
    hresetN = 1'b0;
    hrdatax = {64'hDEAD_BEEF_0123_4567, 64'h0BAD_CAFE_5555_AAAA};
    applyStimulus(1'b0, 32'h1000_0000, NONSEQ, 2'b11, 2'b11, 1'b0);
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_hready", DW'(hready), 64'd1);
    checkOutput("rst_hresp", DW'(hresp), 64'd0);
    checkOutput("rst_hrdata", hrdata, 64'd0);
    checkOutput("rst_err_count", DW'(errCount), 64'd0);
    checkOutput("rst_err_addr", DW'(errAddr), 64'd0);
    checkOutput("rst_hselx", DW'(hselx), 64'd0);
    hresetN = 1'b1;
    applyStimulus(1'b0, '0, IDLE, 2'b11, 2'b00, 1'b0);
    stepCycle();

    $display("[TB] mapped read with one wait state");
    applyStimulus(1'b1, 32'h1000_0040, NONSEQ, 2'b11, 2'b00, 1'b0);
    #1 checkOutput("map_hselx", DW'(hselx), 64'h2);
    stepCycle();
    applyStimulus(1'b0, '0, IDLE, 2'b01, 2'b00, 1'b0);
    #1 checkOutput("map_wait", DW'(hready), 64'd0);
    stepCycle();
    applyStimulus(1'b0, '0, IDLE, 2'b11, 2'b00, 1'b0);
    #1 checkOutput("map_data", hrdata, 64'hDEAD_BEEF_0123_4567);
    checkOutput("map_resp", DW'(hresp), 64'd0);
    stepCycle();

    $display("[TB] unmapped NONSEQ then unmapped IDLE");
    applyStimulus(1'b1, 32'h5000_0000, NONSEQ, 2'b11, 2'b00, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 32'h5000_0000, IDLE, 2'b11, 2'b00, 1'b0);
    #1 checkOutput("err1_ready", DW'(hready), 64'd0);
    checkOutput("err1_resp", DW'(hresp), 64'd1);
    stepCycle();
    #1 checkOutput("err2_ready", DW'(hready), 64'd1);
    checkOutput("err2_resp", DW'(hresp), 64'd1);
    stepCycle();
    #1 checkOutput("idle_ok_resp", DW'(hresp), 64'd0);
    checkOutput("err_cnt_one", DW'(errCount), 64'd1);
    checkOutput("err_addr_cap", DW'(errAddr), 64'h5000_0000);
    stepCycle();
    #1 checkOutput("idle_not_logged", DW'(errCount), 64'd1);
    stepCycle();

    $display("[TB] wait-state hold");
    applyStimulus(1'b1, 32'h0000_0100, NONSEQ, 2'b11, 2'b00, 1'b0);
    stepCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h1000_0200, NONSEQ, 2'b10, 2'b00, 1'b0);
      #1 checkOutput("hold_data", hrdata, 64'h0BAD_CAFE_5555_AAAA);
      stepCycle();
    end
    applyStimulus(1'b0, '0, IDLE, 2'b11, 2'b00, 1'b0);
    stepCycle();
    stepCycle();

    $display("[TB] saturation and clear");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 32'hA000_0000 + AW'(k), NONSEQ, 2'b11, 2'b00, (k == 10));
      if (k == 9) #1 checkOutput("sat_count", DW'(errCount), 64'd3);
      if (k == 11) #1 checkOutput("clear_count", DW'(errCount), 64'd0);
      stepCycle();
    end
    applyStimulus(1'b0, '0, IDLE, 2'b11, 2'b00, 1'b0);
    repeat (3) stepCycle();

    $display("[TB] random traffic");
    for (int k = 0; k < 800; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: nib = 4'h0;
        1: nib = 4'h1;
        2: nib = 4'h5;
        default: nib = 4'hF;
      endcase
      ra[31:28] = nib;
      hrdatax = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(0, 7) != 0), ra, 2'($urandom),
                    {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                    2'($urandom), ($urandom_range(0, 19) == 0));
      stepCycle();
    end

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, 32'h7000_0000, NONSEQ, 2'b11, 2'b00, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, IDLE, 2'b11, 2'b00, 1'b0);
    #2 hresetN = 1'b0;
    #1 checkOutput("midrst_ready", DW'(hready), 64'd1);
    checkOutput("midrst_resp", DW'(hresp), 64'd0);
    checkOutput("midrst_count", DW'(errCount), 64'd0);
    @(negedge clk);
    hresetN = 1'b1;
    modelReset();
    repeat (3) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
